// File: rtl/cs_cs_address_control_if.sv
// rtl/cs_cs_address_control_if.sv - microsequencer address-control bus bundle
interface cs_cs_address_control_if #(
  parameter int ADDR_LENGTH      = 11,
  parameter int COND_LENGTH      = 3,
  parameter int SELECTION_LENGTH = 2
);
  logic [ADDR_LENGTH-1:0]      CS_CS_ADDRESS_CONTROL_data_NextAddr_InBUS;
  logic [ADDR_LENGTH-1:0]      CS_CS_ADDRESS_CONTROL_data_JumpAddr_InBUS;
  logic [COND_LENGTH-1:0]      CS_CS_ADDRESS_CONTROL_data_Cond_InBUS;
  logic                        CS_CS_ADDRESS_CONTROL_data_RD_In;
  logic                        CS_CS_ADDRESS_CONTROL_data_WR_In;
  logic                        CS_CS_ADDRESS_CONTROL_data_MemReady_In;
  logic                        CS_CS_ADDRESS_CONTROL_data_N_In;
  logic                        CS_CS_ADDRESS_CONTROL_data_Z_In;
  logic                        CS_CS_ADDRESS_CONTROL_data_V_In;
  logic                        CS_CS_ADDRESS_CONTROL_data_C_In;
  logic                        CS_CS_ADDRESS_CONTROL_data_IR13_In;
  logic [ADDR_LENGTH-1:0]      CS_CS_ADDRESS_CONTROL_data_Addr_OutBUS;
  logic [ADDR_LENGTH-1:0]      CS_CS_ADDRESS_CONTROL_data_CSAI_OutBUS;
  logic [SELECTION_LENGTH-1:0] CS_CS_ADDRESS_CONTROL_selection_OutBUS;
  logic                        CS_CS_ADDRESS_CONTROL_stall_Out;
  logic                        CS_CS_ADDRESS_CONTROL_halted_Out;

  modport master (
    output CS_CS_ADDRESS_CONTROL_data_NextAddr_InBUS, CS_CS_ADDRESS_CONTROL_data_JumpAddr_InBUS,
           CS_CS_ADDRESS_CONTROL_data_Cond_InBUS, CS_CS_ADDRESS_CONTROL_data_RD_In,
           CS_CS_ADDRESS_CONTROL_data_WR_In, CS_CS_ADDRESS_CONTROL_data_MemReady_In,
           CS_CS_ADDRESS_CONTROL_data_N_In, CS_CS_ADDRESS_CONTROL_data_Z_In,
           CS_CS_ADDRESS_CONTROL_data_V_In, CS_CS_ADDRESS_CONTROL_data_C_In,
           CS_CS_ADDRESS_CONTROL_data_IR13_In,
    input  CS_CS_ADDRESS_CONTROL_data_Addr_OutBUS, CS_CS_ADDRESS_CONTROL_data_CSAI_OutBUS,
           CS_CS_ADDRESS_CONTROL_selection_OutBUS, CS_CS_ADDRESS_CONTROL_stall_Out,
           CS_CS_ADDRESS_CONTROL_halted_Out
  );

  modport slave (
    input  CS_CS_ADDRESS_CONTROL_data_NextAddr_InBUS, CS_CS_ADDRESS_CONTROL_data_JumpAddr_InBUS,
           CS_CS_ADDRESS_CONTROL_data_Cond_InBUS, CS_CS_ADDRESS_CONTROL_data_RD_In,
           CS_CS_ADDRESS_CONTROL_data_WR_In, CS_CS_ADDRESS_CONTROL_data_MemReady_In,
           CS_CS_ADDRESS_CONTROL_data_N_In, CS_CS_ADDRESS_CONTROL_data_Z_In,
           CS_CS_ADDRESS_CONTROL_data_V_In, CS_CS_ADDRESS_CONTROL_data_C_In,
           CS_CS_ADDRESS_CONTROL_data_IR13_In,
    output CS_CS_ADDRESS_CONTROL_data_Addr_OutBUS, CS_CS_ADDRESS_CONTROL_data_CSAI_OutBUS,
           CS_CS_ADDRESS_CONTROL_selection_OutBUS, CS_CS_ADDRESS_CONTROL_stall_Out,
           CS_CS_ADDRESS_CONTROL_halted_Out
  );
endinterface

// File: rtl/cs_cs_address_control.sv
// rtl/cs_cs_address_control.sv - control-store address register, mux selection, memory stall and halt detect
module cs_cs_address_control #(
  parameter int ADDR_LENGTH      = 11,
  parameter int COND_LENGTH      = 3,
  parameter int SELECTION_LENGTH = 2
) (
  input logic CS_CS_ADDRESS_CONTROL_CLOCK_50,
  input logic CS_CS_ADDRESS_CONTROL_RESET_InHigh,
  cs_cs_address_control_if.slave bus
);
  typedef enum logic [1:0] {BOOT, RUN, WAIT_MEM, HALT} state_t;

  localparam logic [SELECTION_LENGTH-1:0] SEL_CSAI   = SELECTION_LENGTH'(0);
  localparam logic [SELECTION_LENGTH-1:0] SEL_JUMP   = SELECTION_LENGTH'(1);
  localparam logic [SELECTION_LENGTH-1:0] SEL_DECODE = SELECTION_LENGTH'(2);

  logic                        clk;
  logic                        rst;
  state_t                      state;
  logic [ADDR_LENGTH-1:0]      addr;
  logic                        stall_r;
  logic                        halted_r;
  logic [SELECTION_LENGTH-1:0] sel;
  logic                        mem_req;
  logic                        mem_ready;
  logic                        halt_idiom;
  logic [COND_LENGTH-1:0]      cond;

  assign clk       = CS_CS_ADDRESS_CONTROL_CLOCK_50;
  assign rst       = CS_CS_ADDRESS_CONTROL_RESET_InHigh;
  assign cond      = bus.CS_CS_ADDRESS_CONTROL_data_Cond_InBUS;
  assign mem_req   = bus.CS_CS_ADDRESS_CONTROL_data_RD_In | bus.CS_CS_ADDRESS_CONTROL_data_WR_In;
  assign mem_ready = bus.CS_CS_ADDRESS_CONTROL_data_MemReady_In;
  assign halt_idiom = (cond == COND_LENGTH'(6)) && !mem_req &&
                      (bus.CS_CS_ADDRESS_CONTROL_data_JumpAddr_InBUS == addr);

  always_comb begin
    sel = SEL_CSAI;
    if (state == RUN || state == WAIT_MEM) begin
      case (cond)
        COND_LENGTH'(1): sel = bus.CS_CS_ADDRESS_CONTROL_data_N_In    ? SEL_JUMP : SEL_CSAI;
        COND_LENGTH'(2): sel = bus.CS_CS_ADDRESS_CONTROL_data_Z_In    ? SEL_JUMP : SEL_CSAI;
        COND_LENGTH'(3): sel = bus.CS_CS_ADDRESS_CONTROL_data_V_In    ? SEL_JUMP : SEL_CSAI;
        COND_LENGTH'(4): sel = bus.CS_CS_ADDRESS_CONTROL_data_C_In    ? SEL_JUMP : SEL_CSAI;
        COND_LENGTH'(5): sel = bus.CS_CS_ADDRESS_CONTROL_data_IR13_In ? SEL_JUMP : SEL_CSAI;
        COND_LENGTH'(6): sel = SEL_JUMP;
        COND_LENGTH'(7): sel = SEL_DECODE;
        default:         sel = SEL_CSAI;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      addr     <= '0;
      stall_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (halt_idiom) begin
            state    <= HALT;
            stall_r  <= 1'b1;
            halted_r <= 1'b1;
          end else if (mem_req && !mem_ready) begin
            state   <= WAIT_MEM;
            stall_r <= 1'b1;
          end else begin
            addr <= bus.CS_CS_ADDRESS_CONTROL_data_NextAddr_InBUS;
          end
        end
        WAIT_MEM: begin
          if (mem_ready) begin
            state   <= RUN;
            stall_r <= 1'b0;
            addr    <= bus.CS_CS_ADDRESS_CONTROL_data_NextAddr_InBUS;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  // BOOT and the first RUN cycle of an unready access stall before the register can catch up
  assign bus.CS_CS_ADDRESS_CONTROL_stall_Out = stall_r ||
                                               (state == RUN && mem_req && !mem_ready) ||
                                               (state == BOOT && !rst);
  assign bus.CS_CS_ADDRESS_CONTROL_halted_Out      = halted_r;
  assign bus.CS_CS_ADDRESS_CONTROL_data_Addr_OutBUS = addr;
  assign bus.CS_CS_ADDRESS_CONTROL_data_CSAI_OutBUS = addr + ADDR_LENGTH'(1);
  assign bus.CS_CS_ADDRESS_CONTROL_selection_OutBUS = sel;
endmodule
